decode_forward_unit: RTL and testbench

Parametrised decode-stage forwarding and hazard unit for the pipelined core. It tracks every in-flight register writer between EX and writeback in an internal slot pipeline and forwards the youngest ready result to each decode-stage read port, for branch resolution and operand capture. It raises a decode stall when the youngest matching writer has not yet produced its value. It replaces the single-port, two-source decode forwarding mux.

---
 rtl/decode_forward_unit.sv | 107 ++++++++++
 tb/tb_decode_forward_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_forward_unit.sv
// Decode-stage forwarding and hazard unit: tracks in-flight register writers from EX to WB
// and forwards the youngest ready result to each decode read port, stalling when it is not ready.
module decode_forward_unit #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int NUM_RD      = 2,
  parameter int DEPTH       = 3,
  parameter int ZERO_REG_EN = 0,
  parameter int SLOT_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [NUM_RD*REG_ADDR_W-1:0] id_rd_addr,
  input  logic [NUM_RD-1:0]            id_rd_used,
  input  logic [NUM_RD*DATA_W-1:0]     id_rf_data,
  input  logic                         id_we,
  input  logic [REG_ADDR_W-1:0]        id_dest,
  input  logic [SLOT_W-1:0]            id_ready_slot,
  input  logic [DEPTH*DATA_W-1:0]      stage_data,
  output logic [NUM_RD*DATA_W-1:0]     fwd_data,
  output logic [NUM_RD-1:0]            fwd_hit,
  output logic                         stall_d,
  output logic [15:0]                  stall_count
);

  logic [DEPTH-1:0]      slotValid_q, slotValid_d;
  logic [DEPTH-1:0]      slotWe_q, slotWe_d;
  logic [REG_ADDR_W-1:0] slotDest_q [DEPTH];
  logic [REG_ADDR_W-1:0] slotDest_d [DEPTH];
  logic [SLOT_W-1:0]     slotReady_q [DEPTH];
  logic [SLOT_W-1:0]     slotReady_d [DEPTH];
  logic [15:0]           stallCount_q, stallCount_d;

  logic [NUM_RD-1:0]     portBlocked;
  logic [REG_ADDR_W-1:0] portAddr;
  logic                  found;

  // Only the youngest matching slot decides; an older ready writer never hides a younger unready one.
  always_comb begin
    fwd_data    = id_rf_data;
    fwd_hit     = '0;
    portBlocked = '0;
    portAddr    = '0;
    found       = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      portAddr = id_rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
      found    = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && slotValid_q[k] && slotWe_q[k] && id_rd_used[p] &&
            (slotDest_q[k] == portAddr) &&
            !((ZERO_REG_EN != 0) && (portAddr == '0))) begin
          found = 1'b1;
          if (k >= int'(slotReady_q[k])) begin
            fwd_data[p*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
            fwd_hit[p]                   = 1'b1;
          end else begin
            portBlocked[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_d     = id_valid & (|portBlocked);
  assign stall_count = stallCount_q;

  always_comb begin
    slotValid_d  = slotValid_q;
    slotWe_d     = slotWe_q;
    slotDest_d   = slotDest_q;
    slotReady_d  = slotReady_q;
    stallCount_d = stallCount_q;
    if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slotValid_d[k] = slotValid_q[k-1];
        slotWe_d[k]    = slotWe_q[k-1];
        slotDest_d[k]  = slotDest_q[k-1];
        slotReady_d[k] = slotReady_q[k-1];
      end
      // A stalled or flushed decode instruction enters EX as a bubble.
      slotValid_d[0] = id_valid & ~stall_d & ~flush;
      slotWe_d[0]    = id_we;
      slotDest_d[0]  = id_dest;
      slotReady_d[0] = id_ready_slot;
      if (stall_d && (stallCount_q != 16'hFFFF)) begin
        stallCount_d = stallCount_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid_q  <= '0;
      stallCount_q <= '0;
    end else begin
      slotValid_q  <= slotValid_d;
      stallCount_q <= stallCount_d;
    end
    slotWe_q    <= slotWe_d;
    slotDest_q  <= slotDest_d;
    slotReady_q <= slotReady_d;
  end

endmodule

// File: tb/tb_decode_forward_unit.sv
// Self-checking bench for decode_forward_unit: a default instance (A) and a deep
// zero-register instance (B) are both checked every cycle against an age-based writer model.
module tb_decode_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        advA, flushA, validA, weA;
  logic [5:0]  addrA;
  logic [1:0]  usedA;
  logic [31:0] rfA;
  logic [2:0]  destA;
  logic [1:0]  readyA;
  logic [47:0] stageA;
  logic [31:0] fwdA;
  logic [1:0]  hitA;
  logic        stallA;
  logic [15:0] countA;

  logic         advB, flushB, validB, weB;
  logic [2:0]   addrB;
  logic [0:0]   usedB;
  logic [15:0]  rfB;
  logic [2:0]   destB;
  logic [5:0]   readyB;
  logic [511:0] stageB;
  logic [15:0]  fwdB;
  logic [0:0]   hitB;
  logic         stallB;
  logic [15:0]  countB;

  decode_forward_unit dutA (
    .clk(clk), .rst(rst), .advance(advA), .flush(flushA), .id_valid(validA),
    .id_rd_addr(addrA), .id_rd_used(usedA), .id_rf_data(rfA), .id_we(weA),
    .id_dest(destA), .id_ready_slot(readyA), .stage_data(stageA),
    .fwd_data(fwdA), .fwd_hit(hitA), .stall_d(stallA), .stall_count(countA)
  );

  decode_forward_unit #(
    .DATA_W(16), .REG_ADDR_W(3), .NUM_RD(1), .DEPTH(32), .ZERO_REG_EN(1), .SLOT_W(6)
  ) dutB (
    .clk(clk), .rst(rst), .advance(advB), .flush(flushB), .id_valid(validB),
    .id_rd_addr(addrB), .id_rd_used(usedB), .id_rf_data(rfB), .id_we(weB),
    .id_dest(destB), .id_ready_slot(readyB), .stage_data(stageB),
    .fwd_data(fwdB), .fwd_hit(hitB), .stall_d(stallB), .stall_count(countB)
  );

  int compared = 0;
  int mismatched = 0;
  bit checkOn = 1'b0;
  bit lastStallB = 1'b0;

  // Model: each pushed instruction carries its age in advance cycles; age == slot index.
  typedef struct {
    bit live;
    bit we;
    int dest;
    int ready;
    int age;
  } hist_t;

  hist_t hist [2][64];
  int    mDepth [2] = '{3, 32};
  bit    mZero [2]  = '{1'b0, 1'b1};
  int    mCount [2] = '{0, 0};

  function automatic int youngest(input int inst, input int addr, input bit used);
    int best;
    best = -1;
    if (!used || (mZero[inst] && addr == 0)) return -1;
    for (int i = 0; i < 64; i++) begin
      if (hist[inst][i].live && hist[inst][i].we && hist[inst][i].dest == addr) begin
        if (best < 0 || hist[inst][i].age < hist[inst][best].age) best = i;
      end
    end
    return best;
  endfunction

  function automatic bit blocked(input int inst, input int addr, input bit used);
    int i;
    i = youngest(inst, addr, used);
    return (i >= 0) && (hist[inst][i].age < hist[inst][i].ready);
  endfunction

  function automatic bit expStallA();
    return validA && (blocked(0, int'(addrA[2:0]), usedA[0]) || blocked(0, int'(addrA[5:3]), usedA[1]));
  endfunction

  function automatic bit expStallB();
    return validB && blocked(1, int'(addrB), usedB[0]);
  endfunction

  task automatic modelStep(input int inst, input bit rstIn, input bit adv, input bit fl,
                           input bit valid, input bit we, input int dest, input int ready,
                           input bit stall);
    bit placed;
    if (rstIn) begin
      for (int i = 0; i < 64; i++) hist[inst][i].live = 1'b0;
      mCount[inst] = 0;
    end else if (adv) begin
      if (stall && mCount[inst] < 65535) mCount[inst]++;
      for (int i = 0; i < 64; i++) begin
        if (hist[inst][i].live) begin
          hist[inst][i].age++;
          if (hist[inst][i].age >= mDepth[inst]) hist[inst][i].live = 1'b0;
        end
      end
      if (valid && !stall && !fl) begin
        placed = 1'b0;
        for (int i = 0; i < 64; i++) begin
          if (!placed && !hist[inst][i].live) begin
            hist[inst][i].live  = 1'b1;
            hist[inst][i].we    = we;
            hist[inst][i].dest  = dest;
            hist[inst][i].ready = ready;
            hist[inst][i].age   = 0;
            placed = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin : modelUpdate
    bit sA;
    bit sB;
    sA = expStallA();
    sB = expStallB();
    lastStallB = sB && advB && !rst;
    modelStep(0, rst, advA, flushA, validA, weA, int'(destA), int'(readyA), sA);
    modelStep(1, rst, advB, flushB, validB, weB, int'(destB), int'(readyB), sB);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Every cycle, both instances are compared against the model on the falling edge.
  always @(negedge clk) begin : compare
    int idx;
    bit sa;
    bit sb;
    bit eh;
    if (checkOn) begin
      sa = expStallA();
      for (int p = 0; p < 2; p++) begin
        idx = youngest(0, int'(addrA[p*3 +: 3]), usedA[p]);
        eh  = (idx >= 0) && (hist[0][idx].age >= hist[0][idx].ready);
        checkOutput($sformatf("A.hit%0d", p), 32'(hitA[p]), 32'(eh));
        if (!sa && !(idx >= 0 && !eh)) begin
          checkOutput($sformatf("A.data%0d", p), 32'(fwdA[p*16 +: 16]),
                      eh ? 32'(stageA[hist[0][idx].age*16 +: 16]) : 32'(rfA[p*16 +: 16]));
        end
      end
      checkOutput("A.stall", 32'(stallA), 32'(sa));
      checkOutput("A.count", 32'(countA), 32'(mCount[0]));

      sb  = expStallB();
      idx = youngest(1, int'(addrB), usedB[0]);
      eh  = (idx >= 0) && (hist[1][idx].age >= hist[1][idx].ready);
      checkOutput("B.hit", 32'(hitB[0]), 32'(eh));
      if (!sb && !(idx >= 0 && !eh)) begin
        checkOutput("B.data", 32'(fwdB),
                    eh ? 32'(stageB[hist[1][idx].age*16 +: 16]) : 32'(rfB));
      end
      checkOutput("B.stall", 32'(stallB), 32'(sb));
      checkOutput("B.count", 32'(countB), 32'(mCount[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit valid, input bit we, input logic [2:0] dest,
                               input logic [1:0] ready, input logic [2:0] a0,
                               input logic [2:0] a1, input logic [1:0] used);
    validA = valid;
    weA    = we;
    destA  = dest;
    readyA = ready;
    addrA  = {a1, a0};
    usedA  = used;
  endtask

  task automatic applyStimulusB(input bit valid, input bit we, input logic [2:0] dest,
                                input logic [5:0] ready, input logic [2:0] addr, input bit used);
    validB   = valid;
    weB      = we;
    destB    = dest;
    readyB   = ready;
    addrB    = addr;
    usedB[0] = used;
  endtask

  task automatic idleA(input int n);
    applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd0, 2'b00);
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int seen;
    rst = 1'b1;
    advA = 1'b1; flushA = 1'b0; rfA = '0;
    stageA = {16'hC002, 16'hBEEF, 16'hA000};
    applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd0, 2'b00);
    advB = 1'b1; flushB = 1'b0; rfB = '0;
    for (int k = 0; k < 32; k++) stageB[k*16 +: 16] = 16'h5000 + 16'(k);
    applyStimulusB(1'b0, 1'b0, 3'd0, 6'd0, 3'd0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    checkOn = 1'b1;

    // Reset then idle
    rfA = {16'h2222, 16'h1111};
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd3, 3'd5, 2'b01);
    @(negedge clk);
    checkOutput("lit.idle.data", 32'(fwdA[15:0]), 32'h1111);
    checkOutput("lit.idle.hit", 32'(hitA), 32'h0);
    checkOutput("lit.idle.stall", 32'(stallA), 32'h0);
    checkOutput("lit.idle.count", 32'(countA), 32'h0);
    tick();

    // ALU writer read back-to-back
    applyStimulus(1'b1, 1'b1, 3'd3, 2'd1, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd3, 3'd0, 2'b01);
    @(negedge clk);
    checkOutput("lit.alu.stall", 32'(stallA), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit.alu.data", 32'(fwdA[15:0]), 32'hBEEF);
    checkOutput("lit.alu.hit", 32'(hitA[0]), 32'h1);
    checkOutput("lit.alu.count", 32'(countA), 32'h1);
    tick();
    idleA(3);

    // Load-use on both ports
    applyStimulus(1'b1, 1'b1, 3'd2, 2'd2, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd2, 3'd2, 2'b11);
    @(negedge clk);
    checkOutput("lit.load.stall1", 32'(stallA), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit.load.stall2", 32'(stallA), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit.load.data", 32'(fwdA), 32'hC002C002);
    checkOutput("lit.load.hit", 32'(hitA), 32'h3);
    checkOutput("lit.load.count", 32'(countA), 32'h3);
    tick();
    idleA(3);

    // Priority: youngest ready writer wins
    stageA = {16'h0002, 16'h0001, 16'hA000};
    applyStimulus(1'b1, 1'b1, 3'd4, 2'd1, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd4, 2'd1, 3'd0, 3'd0, 2'b00);
    tick();
    idleA(1);
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd4, 3'd0, 2'b01);
    @(negedge clk);
    checkOutput("lit.prio.data", 32'(fwdA[15:0]), 32'h0001);
    checkOutput("lit.prio.stall", 32'(stallA), 32'h0);
    tick();
    idleA(3);

    // Priority: a younger unready load blocks an older ready writer
    applyStimulus(1'b1, 1'b1, 3'd4, 2'd1, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd4, 2'd2, 3'd0, 3'd0, 2'b00);
    tick();
    idleA(1);
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd4, 3'd0, 2'b01);
    @(negedge clk);
    checkOutput("lit.prioLoad.stall", 32'(stallA), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit.prioLoad.data", 32'(fwdA[15:0]), 32'h0002);
    checkOutput("lit.prioLoad.count", 32'(countA), 32'h4);
    tick();
    idleA(3);

    // Freeze while stalled, then flush while stalled
    applyStimulus(1'b1, 1'b1, 3'd6, 2'd2, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd6, 3'd0, 2'b01);
    advA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("lit.freeze.stall", 32'(stallA), 32'h1);
      checkOutput("lit.freeze.count", 32'(countA), 32'h4);
      tick();
    end
    advA = 1'b1;
    flushA = 1'b1;
    tick();
    flushA = 1'b0;
    @(negedge clk);
    checkOutput("lit.flushStall.stall", 32'(stallA), 32'h1);
    checkOutput("lit.flushStall.count", 32'(countA), 32'h5);
    tick();
    @(negedge clk);
    checkOutput("lit.flushStall.data", 32'(fwdA[15:0]), 32'h0002);
    checkOutput("lit.flushStall.count2", 32'(countA), 32'h6);
    tick();
    idleA(3);

    // A flushed writer is never pushed
    rfA = {16'h2222, 16'h7777};
    applyStimulus(1'b1, 1'b1, 3'd7, 2'd1, 3'd0, 3'd0, 2'b00);
    flushA = 1'b1;
    tick();
    flushA = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd7, 3'd0, 2'b01);
    @(negedge clk);
    checkOutput("lit.flush.stall", 32'(stallA), 32'h0);
    checkOutput("lit.flush.hit", 32'(hitA), 32'h0);
    checkOutput("lit.flush.data", 32'(fwdA[15:0]), 32'h7777);
    tick();
    idleA(3);

    // Reset in the middle of a stall
    applyStimulus(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 3'd0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 3'd1, 3'd0, 2'b01);
    @(negedge clk);
    checkOutput("lit.rst.stallBefore", 32'(stallA), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("lit.rst.stallAfter", 32'(stallA), 32'h0);
    checkOutput("lit.rst.count", 32'(countA), 32'h0);
    tick();
    idleA(2);

    // Zero register on instance B
    rfB = 16'h3333;
    applyStimulusB(1'b1, 1'b1, 3'd0, 6'd1, 3'd0, 1'b0);
    tick();
    applyStimulusB(1'b1, 1'b0, 3'd0, 6'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("lit.zero.stall", 32'(stallB), 32'h0);
    checkOutput("lit.zero.hit", 32'(hitB), 32'h0);
    checkOutput("lit.zero.data", 32'(fwdB), 32'h3333);
    tick();
    applyStimulusB(1'b1, 1'b1, 3'd1, 6'd1, 3'd0, 1'b0);
    tick();
    applyStimulusB(1'b1, 1'b0, 3'd0, 6'd0, 3'd1, 1'b1);
    @(negedge clk);
    checkOutput("lit.r1.stall", 32'(stallB), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit.r1.data", 32'(fwdB), 32'h5001);
    checkOutput("lit.r1.count", 32'(countB), 32'h1);
    tick();

    // Saturation: a self-dependent never-ready writer keeps decode stalled
    applyStimulusB(1'b1, 1'b1, 3'd5, 6'd63, 3'd5, 1'b1);
    n = 0;
    while (mCount[1] != 65534 && n < 75000) begin
      tick();
      n++;
    end
    if (mCount[1] != 65534) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL sat.reach: actual %0d required 65534", mCount[1]);
    end else begin
      @(negedge clk);
      checkOutput("lit.sat.fffe", 32'(countB), 32'hFFFE);
      seen = 0;
      n = 0;
      while (seen < 3 && n < 100) begin
        tick();
        n++;
        if (lastStallB) seen++;
      end
      @(negedge clk);
      checkOutput("lit.sat.ffff", 32'(countB), 32'hFFFF);
    end
    applyStimulusB(1'b0, 1'b0, 3'd0, 6'd0, 3'd0, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
